// File: rtl/hazard_unit_if.sv
// Hazard unit port bundle: ID/EX operand info, memory
// handshake status, pipe-register controls and stall counters.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs1_i;
  logic [REG_W-1:0] id_rs2_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic             ex_mem_read_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             ex_br_taken_i;
  logic             imem_req_i;
  logic             imem_resp_i;
  logic             dmem_req_i;
  logic             dmem_resp_i;
  logic             HD_PC_write_o;
  logic             HD_IF_ID_write_o;
  logic             HD_controlmux_sel_o;
  logic             HD_ID_EX_write_o;
  logic             HD_EX_MEM_write_o;
  logic             HD_MEM_WB_write_o;
  logic             HD_IF_ID_flush_o;
  logic             HD_ID_EX_flush_o;
  logic [CNT_W-1:0] lu_stall_cnt_o;
  logic [CNT_W-1:0] mem_stall_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i,
    output id_uses_rs1_i, id_uses_rs2_i,
    output ex_mem_read_i, ex_rd_i,
    output ex_br_taken_i,
    output imem_req_i, imem_resp_i,
    output dmem_req_i, dmem_resp_i,
    input  HD_PC_write_o, HD_IF_ID_write_o,
    input  HD_controlmux_sel_o,
    input  HD_ID_EX_write_o,
    input  HD_EX_MEM_write_o,
    input  HD_MEM_WB_write_o,
    input  HD_IF_ID_flush_o,
    input  HD_ID_EX_flush_o,
    input  lu_stall_cnt_o, mem_stall_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i,
    input  id_uses_rs1_i, id_uses_rs2_i,
    input  ex_mem_read_i, ex_rd_i,
    input  ex_br_taken_i,
    input  imem_req_i, imem_resp_i,
    input  dmem_req_i, dmem_resp_i,
    output HD_PC_write_o, HD_IF_ID_write_o,
    output HD_controlmux_sel_o,
    output HD_ID_EX_write_o,
    output HD_EX_MEM_write_o,
    output HD_MEM_WB_write_o,
    output HD_IF_ID_flush_o,
    output HD_ID_EX_flush_o,
    output lu_stall_cnt_o, mem_stall_cnt_o
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, memory freeze,
// taken-branch flush (deferred across freezes), stall counters.
module hazard_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  typedef enum logic {
    RUN,
    LU_STALL
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       cnt, cnt_nx;
  logic             flush_pend, flush_pend_nx;
  logic [CNT_W-1:0] lu_cnt, mem_cnt;
  logic             lu_inc, mem_inc;

  logic mem_wait, lu_hit, flush_now, lu_stall;
  logic sel_mem, sel_fl, sel_lu, sel_run;

  logic pc_w, ifid_w, cm_sel;
  logic idex_w, exmem_w, memwb_w;
  logic ifid_fl, idex_fl;

  assign mem_wait =
    (hz.imem_req_i & ~hz.imem_resp_i) |
    (hz.dmem_req_i & ~hz.dmem_resp_i);

  assign lu_hit = hz.ex_mem_read_i &
    (hz.ex_rd_i != '0) &
    ((hz.id_uses_rs1_i & (hz.ex_rd_i == hz.id_rs1_i)) |
     (hz.id_uses_rs2_i & (hz.ex_rd_i == hz.id_rs2_i)));

  assign flush_now =
    (hz.ex_br_taken_i | flush_pend) & ~mem_wait;

  assign lu_stall =
    ((state == RUN) & lu_hit) | (state == LU_STALL);

  // mutually exclusive priority classes
  assign sel_mem = mem_wait;
  assign sel_fl  = flush_now;
  assign sel_lu  = lu_stall & ~mem_wait & ~flush_now;
  assign sel_run = ~sel_mem & ~sel_fl & ~sel_lu;

  always_comb begin
    pc_w          = 1'b1;
    ifid_w        = 1'b1;
    cm_sel        = 1'b1;
    idex_w        = 1'b1;
    exmem_w       = 1'b1;
    memwb_w       = 1'b1;
    ifid_fl       = 1'b0;
    idex_fl       = 1'b0;
    state_nx      = state;
    cnt_nx        = cnt;
    flush_pend_nx = flush_pend;
    lu_inc        = 1'b0;
    mem_inc       = 1'b0;
    unique case (1'b1)
      sel_mem: begin
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        idex_w  = 1'b0;
        exmem_w = 1'b0;
        memwb_w = 1'b0;
        mem_inc = 1'b1;
        if (hz.ex_br_taken_i)
          flush_pend_nx = 1'b1;
      end
      sel_fl: begin
        ifid_fl       = 1'b1;
        idex_fl       = 1'b1;
        flush_pend_nx = 1'b0;
        state_nx      = RUN;
        cnt_nx        = '0;
      end
      sel_lu: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        cm_sel = 1'b0;
        lu_inc = 1'b1;
        if (state == RUN) begin
          if (LOAD_LAT > 1) begin
            state_nx = LU_STALL;
            cnt_nx   = 3'(LOAD_LAT - 1);
          end
        end else if (cnt == 3'd1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      sel_run: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      flush_pend <= flush_pend_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt  <= '0;
      mem_cnt <= '0;
    end else begin
      if (lu_inc && lu_cnt != '1)
        lu_cnt <= lu_cnt + CNT_W'(1);
      if (mem_inc && mem_cnt != '1)
        mem_cnt <= mem_cnt + CNT_W'(1);
    end
  end

  assign hz.HD_PC_write_o       = pc_w;
  assign hz.HD_IF_ID_write_o    = ifid_w;
  assign hz.HD_controlmux_sel_o = cm_sel;
  assign hz.HD_ID_EX_write_o    = idex_w;
  assign hz.HD_EX_MEM_write_o   = exmem_w;
  assign hz.HD_MEM_WB_write_o   = memwb_w;
  assign hz.HD_IF_ID_flush_o    = ifid_fl;
  assign hz.HD_ID_EX_flush_o    = idex_fl;
  assign hz.lu_stall_cnt_o      = lu_cnt;
  assign hz.mem_stall_cnt_o     = mem_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (LOAD_LAT 1/3/2, the last
// with 2-bit counters) share one stimulus and a bubble-count model.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       ireq;
    logic       iresp;
    logic       dreq;
    logic       dresp;
  } stim_t;

  localparam logic [7:0] O_RUN = 8'b1111_1100;
  localparam logic [7:0] O_LU  = 8'b0001_1100;
  localparam logic [7:0] O_MEM = 8'b0010_0000;
  localparam logic [7:0] O_FL  = 8'b1111_1111;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t s   = '0;

  int vec  = 0;
  int miss = 0;

  int     lat[3] = '{1, 3, 2};
  longint cap[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};
  int     rem[3];
  bit     fp[3];
  longint luc[3];
  longint memc[3];

  logic [7:0]  outs[3];
  logic [31:0] lug[3];
  logic [31:0] mg[3];

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_W(5), .CNT_W(32)) if1 ();
  hazard_unit_if #(.REG_W(5), .CNT_W(32)) if3 ();
  hazard_unit_if #(.REG_W(5), .CNT_W(2))  if2 ();

  hazard_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .hz(if1.slave));
  hazard_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(32)) u3 (
    .clk(clk), .rst(rst), .hz(if3.slave));
  hazard_unit #(.REG_W(5), .LOAD_LAT(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .hz(if2.slave));

  assign if1.id_rs1_i      = s.rs1;
  assign if1.id_rs2_i      = s.rs2;
  assign if1.id_uses_rs1_i = s.u1;
  assign if1.id_uses_rs2_i = s.u2;
  assign if1.ex_mem_read_i = s.mr;
  assign if1.ex_rd_i       = s.rd;
  assign if1.ex_br_taken_i = s.br;
  assign if1.imem_req_i    = s.ireq;
  assign if1.imem_resp_i   = s.iresp;
  assign if1.dmem_req_i    = s.dreq;
  assign if1.dmem_resp_i   = s.dresp;

  assign if3.id_rs1_i      = s.rs1;
  assign if3.id_rs2_i      = s.rs2;
  assign if3.id_uses_rs1_i = s.u1;
  assign if3.id_uses_rs2_i = s.u2;
  assign if3.ex_mem_read_i = s.mr;
  assign if3.ex_rd_i       = s.rd;
  assign if3.ex_br_taken_i = s.br;
  assign if3.imem_req_i    = s.ireq;
  assign if3.imem_resp_i   = s.iresp;
  assign if3.dmem_req_i    = s.dreq;
  assign if3.dmem_resp_i   = s.dresp;

  assign if2.id_rs1_i      = s.rs1;
  assign if2.id_rs2_i      = s.rs2;
  assign if2.id_uses_rs1_i = s.u1;
  assign if2.id_uses_rs2_i = s.u2;
  assign if2.ex_mem_read_i = s.mr;
  assign if2.ex_rd_i       = s.rd;
  assign if2.ex_br_taken_i = s.br;
  assign if2.imem_req_i    = s.ireq;
  assign if2.imem_resp_i   = s.iresp;
  assign if2.dmem_req_i    = s.dreq;
  assign if2.dmem_resp_i   = s.dresp;

  assign outs[0] = {if1.HD_PC_write_o, if1.HD_IF_ID_write_o,
    if1.HD_controlmux_sel_o, if1.HD_ID_EX_write_o,
    if1.HD_EX_MEM_write_o, if1.HD_MEM_WB_write_o,
    if1.HD_IF_ID_flush_o, if1.HD_ID_EX_flush_o};
  assign outs[1] = {if3.HD_PC_write_o, if3.HD_IF_ID_write_o,
    if3.HD_controlmux_sel_o, if3.HD_ID_EX_write_o,
    if3.HD_EX_MEM_write_o, if3.HD_MEM_WB_write_o,
    if3.HD_IF_ID_flush_o, if3.HD_ID_EX_flush_o};
  assign outs[2] = {if2.HD_PC_write_o, if2.HD_IF_ID_write_o,
    if2.HD_controlmux_sel_o, if2.HD_ID_EX_write_o,
    if2.HD_EX_MEM_write_o, if2.HD_MEM_WB_write_o,
    if2.HD_IF_ID_flush_o, if2.HD_ID_EX_flush_o};

  assign lug[0] = if1.lu_stall_cnt_o;
  assign lug[1] = if3.lu_stall_cnt_o;
  assign lug[2] = {30'd0, if2.lu_stall_cnt_o};
  assign mg[0]  = if1.mem_stall_cnt_o;
  assign mg[1]  = if3.mem_stall_cnt_o;
  assign mg[2]  = {30'd0, if2.mem_stall_cnt_o};

  // model: rem = bubbles still owed after the current cycle
  function automatic bit m_wait();
    return (s.ireq && !s.iresp) || (s.dreq && !s.dresp);
  endfunction

  function automatic bit m_hit();
    bit a = s.u1 && (s.rd == s.rs1);
    bit b = s.u2 && (s.rd == s.rs2);
    return s.mr && (s.rd != 0) && (a || b);
  endfunction

  function automatic logic [7:0] exp_o(int k);
    bit fl = (s.br || fp[k]) && !m_wait();
    if (m_wait()) return O_MEM;
    if (fl) return O_FL;
    if (rem[k] > 0 || m_hit()) return O_LU;
    return O_RUN;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit fl = (s.br || fp[k]) && !m_wait();
      if (m_wait()) begin
        if (s.br) fp[k] = 1'b1;
        if (memc[k] < cap[k]) memc[k]++;
      end else if (fl) begin
        fp[k]  = 1'b0;
        rem[k] = 0;
      end else if (rem[k] > 0 || m_hit()) begin
        if (luc[k] < cap[k]) luc[k]++;
        if (rem[k] > 0) rem[k]--;
        else rem[k] = lat[k] - 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k]  = 0;
      fp[k]   = 1'b0;
      luc[k]  = 0;
      memc[k] = 0;
    end
  endtask

  task automatic do_reset();
    s   = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic stim_t mk_hit(logic br);
    stim_t h = '0;
    h.mr  = 1'b1;
    h.rd  = 5'd5;
    h.rs2 = 5'd5;
    h.u2  = 1'b1;
    h.br  = br;
    return h;
  endfunction

  function automatic stim_t mk_dwait();
    stim_t h = '0;
    h.dreq = 1'b1;
    return h;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s   = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (outs[k] !== O_RUN || lug[k] !== 0 || mg[k] !== 0) begin
        miss++;
        $display("FAIL reset dut%0d: outs=%b lu=%0d mem=%0d need %b 0 0",
          k, outs[k], lug[k], mg[k], O_RUN);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_lu_lat1();
    stim_t q[$];
    do_reset();
    q = '{mk_hit(1'b0), stim_t'(0), stim_t'(0), stim_t'(0)};
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== exp_o(k) || lug[k] !== 32'(luc[k])) begin
          miss++;
          $display("FAIL lu_lat1 dut%0d c%0d: outs=%b lu=%0d need %b %0d",
            k, i, outs[k], lug[k], exp_o(k), luc[k]);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    vec++;
    if (lug[0] !== 32'd1) begin
      miss++;
      $display("FAIL lu_lat1_cnt: lu=%0d need 1", lug[0]);
    end
  endtask

  task automatic test_filter();
    stim_t q[$];
    stim_t a = '0;
    stim_t b = '0;
    do_reset();
    a.mr = 1'b1; a.u1 = 1'b1; a.u2 = 1'b1;
    b.mr = 1'b1; b.rd = 5'd7; b.rs1 = 5'd7;
    b.u2 = 1'b1; b.rs2 = 5'd3;
    q = '{a, b};
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== O_RUN) begin
          miss++;
          $display("FAIL filter dut%0d c%0d: outs=%b need %b",
            k, i, outs[k], O_RUN);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    vec++;
    if (lug[1] !== 32'd0) begin
      miss++;
      $display("FAIL filter_cnt: lu=%0d need 0", lug[1]);
    end
  endtask

  task automatic test_lu_lat3();
    stim_t q[$];
    int nb = 0;
    do_reset();
    q = '{mk_hit(1'b0), stim_t'(0), stim_t'(0),
          stim_t'(0), stim_t'(0)};
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      if (outs[1] == O_LU) nb++;
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== exp_o(k) || lug[k] !== 32'(luc[k])) begin
          miss++;
          $display("FAIL lu_lat3 dut%0d c%0d: outs=%b lu=%0d need %b %0d",
            k, i, outs[k], lug[k], exp_o(k), luc[k]);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    vec++;
    if (lug[1] !== 32'd3 || nb != 3) begin
      miss++;
      $display("FAIL lu_lat3_cnt: lu=%0d bubbles=%0d need 3 3",
        lug[1], nb);
    end
  endtask

  task automatic test_mem_freeze();
    stim_t q[$];
    do_reset();
    q = '{mk_hit(1'b0), mk_dwait(), mk_dwait(), mk_dwait(),
          mk_dwait(), stim_t'(0), stim_t'(0), stim_t'(0)};
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== exp_o(k) || mg[k] !== 32'(memc[k])) begin
          miss++;
          $display("FAIL mem_freeze dut%0d c%0d: outs=%b mem=%0d need %b %0d",
            k, i, outs[k], mg[k], exp_o(k), memc[k]);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    vec++;
    if (lug[1] !== 32'd3 || mg[1] !== 32'd4) begin
      miss++;
      $display("FAIL mem_freeze_cnt: lu=%0d mem=%0d need 3 4",
        lug[1], mg[1]);
    end
  endtask

  task automatic test_branch_defer();
    stim_t q[$];
    stim_t w = '0;
    stim_t wb = '0;
    stim_t r = '0;
    do_reset();
    w.ireq = 1'b1;
    wb = w; wb.br = 1'b1;
    r.ireq = 1'b1; r.iresp = 1'b1;
    q = '{wb, w, r, stim_t'(0)};
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== exp_o(k)) begin
          miss++;
          $display("FAIL br_defer dut%0d c%0d: outs=%b need %b",
            k, i, outs[k], exp_o(k));
        end
      end
      if (i == 2) begin
        vec++;
        if (outs[0] !== O_FL) begin
          miss++;
          $display("FAIL br_defer_flush: outs=%b need %b",
            outs[0], O_FL);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush_cancel();
    stim_t q[$];
    do_reset();
    q = '{mk_hit(1'b1), stim_t'(0), stim_t'(0)};
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== exp_o(k)) begin
          miss++;
          $display("FAIL flush_cancel dut%0d c%0d: outs=%b need %b",
            k, i, outs[k], exp_o(k));
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    vec++;
    if (lug[2] !== 32'd0) begin
      miss++;
      $display("FAIL flush_cancel_cnt: lu=%0d need 0", lug[2]);
    end
  endtask

  task automatic test_rst_mid();
    stim_t w = '0;
    do_reset();
    s = mk_hit(1'b0);
    @(posedge clk);
    #1;
    s = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vec++;
    if (outs[1] !== O_RUN || lug[1] !== 32'd0) begin
      miss++;
      $display("FAIL rst_mid_stall: outs=%b lu=%0d need %b 0",
        outs[1], lug[1], O_RUN);
    end
    rst = 1'b0;
    model_reset();
    w.ireq = 1'b1;
    w.br   = 1'b1;
    s = w;
    @(posedge clk);
    #1;
    s = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (outs[k] !== O_RUN || mg[k] !== 0) begin
        miss++;
        $display("FAIL rst_pend dut%0d: outs=%b mem=%0d need %b 0",
          k, outs[k], mg[k], O_RUN);
      end
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    stim_t q[$];
    do_reset();
    for (int j = 0; j < 5; j++) begin
      q.push_back(mk_hit(1'b0));
      q.push_back(stim_t'(0));
    end
    for (int j = 0; j < 5; j++) q.push_back(mk_dwait());
    foreach (q[i]) begin
      s = q[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (lug[k] !== 32'(luc[k]) || mg[k] !== 32'(memc[k])) begin
          miss++;
          $display("FAIL saturate dut%0d c%0d: lu=%0d mem=%0d need %0d %0d",
            k, i, lug[k], mg[k], luc[k], memc[k]);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    vec++;
    if (lug[2] !== 32'd3 || mg[2] !== 32'd3 || lug[0] !== 32'd5) begin
      miss++;
      $display("FAIL saturate_end: lu2=%0d mem2=%0d lu0=%0d need 3 3 5",
        lug[2], mg[2], lug[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.mr    = ($urandom_range(0, 2) == 0);
      s.br    = ($urandom_range(0, 9) == 0);
      s.ireq  = ($urandom_range(0, 3) == 0);
      s.iresp = ($urandom_range(0, 1) == 0);
      s.dreq  = ($urandom_range(0, 4) == 0);
      s.dresp = ($urandom_range(0, 1) == 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vec++;
        if (outs[k] !== exp_o(k) || lug[k] !== 32'(luc[k]) ||
            mg[k] !== 32'(memc[k])) begin
          miss++;
          $display("FAIL random dut%0d c%0d: outs=%b lu=%0d mem=%0d need %b %0d %0d",
            k, i, outs[k], lug[k], mg[k], exp_o(k), luc[k], memc[k]);
        end
      end
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lu_lat1();
    test_filter();
    test_lu_lat3();
    test_mem_freeze();
    test_branch_defer();
    test_flush_cancel();
    test_rst_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
